// File: rtl/imem_pkg.sv
// Shared types for the boot-loaded instruction memory: loader FSM states, the NOP word
// and the fetch result codes.
package imem_pkg;

    typedef enum logic [1:0] {
        StClear,
        StLoad,
        StRun
    } state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FetchNone,
        FetchOk,
        FetchMisalign,
        FetchRange
    } fetch_e;

endpackage

// File: rtl/imem_ram.sv
// Single-write-port storage array with a registered read port; the read register holds
// its value while re is low.
module imem_ram #(
    parameter int unsigned n     = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [n-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [n-1:0]  rdata
);

    logic [n-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory for the fetch stage: cleared after reset, filled through a streaming
// load handshake, then read with a registered fetch port that supports stall and flush.
module imem_boot_loader
    import imem_pkg::*;
#(
    parameter int unsigned  n     = 32,
    parameter int unsigned  DEPTH = 256,
    parameter logic [n-1:0] NOP   = n'(NOP_WORD)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] PC,
    input  logic         stall,
    input  logic         flush,
    output logic [n-1:0] instruction,
    output logic         inst_valid,
    output logic         addr_err,
    output logic         mem_ready,
    input  logic         ld_start,
    input  logic         ld_valid,
    input  logic [n-1:0] ld_data,
    input  logic         ld_last,
    output logic         ld_ready,
    output logic         ld_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e        state;
    logic [AW-1:0] clr_ptr;
    logic [AW:0]   wr_ptr;
    logic          wr_full;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [n-1:0]  ram_wdata;
    logic [n-1:0]  ram_rdata;

    fetch_e        fetch_q;
    logic [n-1:0]  pc_word;
    logic          misalign;
    logic          out_of_range;

    // One extra pointer bit lets wr_ptr reach DEPTH and saturate there.
    assign wr_full = (wr_ptr == (AW + 1)'(DEPTH));

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_ptr;
        ram_wdata = NOP;
        if (state == StClear) begin
            ram_we = 1'b1;
        end else if (state == StLoad && ld_valid && !wr_full) begin
            ram_we    = 1'b1;
            ram_waddr = wr_ptr[AW-1:0];
            ram_wdata = ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StClear;
            clr_ptr   <= '0;
            wr_ptr    <= '0;
            mem_ready <= 1'b0;
            ld_ready  <= 1'b0;
            ld_ovf    <= 1'b0;
        end else begin
            unique case (state)
                StClear: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr) begin
                        state    <= StLoad;
                        ld_ready <= 1'b1;
                    end
                end
                StLoad: begin
                    if (ld_valid) begin
                        if (wr_full) begin
                            ld_ovf <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                        if (ld_last) begin
                            state     <= StRun;
                            ld_ready  <= 1'b0;
                            mem_ready <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (ld_start) begin
                        state     <= StLoad;
                        wr_ptr    <= '0;
                        ld_ready  <= 1'b1;
                        mem_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= StClear;
                end
            endcase
        end
    end

    imem_ram #(
        .n     (n),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (!stall),
        .raddr (PC[AW+1:2]),
        .rdata (ram_rdata)
    );

    // Range test on the full word index so high PC bits never alias into the array.
    assign pc_word      = PC >> 2;
    assign misalign     = |PC[1:0];
    assign out_of_range = (pc_word >= n'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_q <= FetchNone;
        end else if (state != StRun || flush) begin
            fetch_q <= FetchNone;
        end else if (!stall) begin
            if (misalign) begin
                fetch_q <= FetchMisalign;
            end else if (out_of_range) begin
                fetch_q <= FetchRange;
            end else begin
                fetch_q <= FetchOk;
            end
        end
    end

    assign inst_valid  = (fetch_q == FetchOk);
    assign addr_err    = (fetch_q == FetchMisalign) || (fetch_q == FetchRange);
    assign instruction = inst_valid ? ram_rdata : NOP;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader (DEPTH=8): fetch vector table driven through a
// scoreboard queue, plus hand-written load, overflow and reset sequences.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  PC = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  instruction;
    logic          inst_valid;
    logic          addr_err;
    logic          mem_ready;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [N-1:0]  ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          ld_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic [31:0] instr;
        logic        valid;
        logic        err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[17];

    imem_boot_loader #(
        .n     (N),
        .DEPTH (DEPTH),
        .NOP   (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .stall       (stall),
        .flush       (flush),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .addr_err    (addr_err),
        .mem_ready   (mem_ready),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_ovf      (ld_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (got running, want finished)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_fetch(input string name, input logic [31:0] pc, input logic st,
                               input logic fl, input logic [31:0] ei, input logic ev,
                               input logic ee);
        exp_t e;
        PC    = pc;
        stall = st;
        flush = fl;
        e.instr = ei;
        e.valid = ev;
        e.err   = ee;
        sb_q.push_back(e);
        tick();
        stall = 1'b0;
        flush = 1'b0;
        e = sb_q.pop_front();
        chk({name, "_instr"}, instruction, e.instr);
        chk({name, "_valid"}, 32'(inst_valid), 32'(e.valid));
        chk({name, "_err"}, 32'(addr_err), 32'(e.err));
    endtask

    // Streams cnt words base+k; ld_last on the final word if with_last; ld_start pulsed at
    // index start_at (ignored by the DUT outside RUN).
    task automatic load(input logic [31:0] base, input int cnt, input logic with_last,
                        input int start_at);
        for (int k = 0; k < cnt; k++) begin
            ld_valid = 1'b1;
            ld_data  = base + 32'(k);
            ld_last  = with_last && (k == cnt - 1);
            ld_start = (k == start_at);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_start = 1'b0;
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{32'h18,        1'b0, 1'b0, 32'h1000_0006, 1'b1, 1'b0};
        vecs[1]  = '{32'h00,        1'b0, 1'b0, 32'h1000_0000, 1'b1, 1'b0};
        vecs[2]  = '{32'h1C,        1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
        vecs[3]  = '{32'h20,        1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[4]  = '{32'h06,        1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[5]  = '{32'h10,        1'b0, 1'b0, 32'h1000_0004, 1'b1, 1'b0};
        vecs[6]  = '{32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[7]  = '{32'h04,        1'b0, 1'b1, 32'h0,         1'b0, 1'b0};
        vecs[8]  = '{32'h00,        1'b0, 1'b0, 32'h1000_0000, 1'b1, 1'b0};
        vecs[9]  = '{32'h04,        1'b1, 1'b0, 32'h1000_0000, 1'b1, 1'b0};
        vecs[10] = '{32'h08,        1'b1, 1'b0, 32'h1000_0000, 1'b1, 1'b0};
        vecs[11] = '{32'h04,        1'b1, 1'b1, 32'h0,         1'b0, 1'b0};
        vecs[12] = '{32'h20,        1'b1, 1'b0, 32'h0,         1'b0, 1'b0};
        vecs[13] = '{32'h20,        1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[14] = '{32'h21,        1'b1, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[15] = '{32'h0C,        1'b0, 1'b0, 32'h1000_0003, 1'b1, 1'b0};
        vecs[16] = '{32'h44,        1'b0, 1'b0, 32'h0,         1'b0, 1'b1};

        // T1: reset state, then DEPTH clear cycles before the loader opens
        tick();
        tick();
        chk("rst_instr", instruction, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_err", 32'(addr_err), 32'h0);
        chk("rst_mem_ready", 32'(mem_ready), 32'h0);
        chk("rst_ld_ready", 32'(ld_ready), 32'h0);
        chk("rst_ld_ovf", 32'(ld_ovf), 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            ld_valid = (i <= 4);
            ld_last  = (i <= 4);
            ld_data  = 32'hDEAD_BEEF;
            tick();
            chk($sformatf("clear%0d_mem_ready", i), 32'(mem_ready), 32'h0);
            chk($sformatf("clear%0d_ld_ready", i), 32'(ld_ready), 32'(i == 8));
            chk($sformatf("clear%0d_valid", i), 32'(inst_valid), 32'h0);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;

        // T2: ld_last alone is ignored, then 7 words with the fetch address already set
        ld_last = 1'b1;
        tick();
        ld_last = 1'b0;
        chk("lastonly_mem_ready", 32'(mem_ready), 32'h0);
        chk("lastonly_ld_ready", 32'(ld_ready), 32'h1);
        PC = 32'h18;
        load(32'h1000_0000, 6, 1'b0, -1);
        chk("t2_pre_mem_ready", 32'(mem_ready), 32'h0);
        load(32'h1000_0006, 1, 1'b1, -1);
        chk("t2_mem_ready", 32'(mem_ready), 32'h1);
        chk("t2_ld_ready", 32'(ld_ready), 32'h0);
        chk("t2_load_edge_valid", 32'(inst_valid), 32'h0);

        // T3/T4: fetch vectors through the scoreboard
        for (int i = 0; i < 17; i++) begin
            apply_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].stall, vecs[i].flush,
                        vecs[i].instr, vecs[i].valid, vecs[i].err);
        end

        // RUN->LOAD edge still fetches with the pre-edge state
        PC       = 32'h04;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("rtl_instr", instruction, 32'h1000_0001);
        chk("rtl_valid", 32'(inst_valid), 32'h1);
        chk("rtl_ld_ready", 32'(ld_ready), 32'h1);
        chk("rtl_mem_ready", 32'(mem_ready), 32'h0);
        tick();
        chk("load_fetch_valid", 32'(inst_valid), 32'h0);
        chk("load_fetch_instr", instruction, 32'h0);

        // T5: 9 words into 8 slots; ld_start mid-stream must be ignored
        load(32'h2000_0000, 8, 1'b0, 3);
        chk("t5_ovf_before", 32'(ld_ovf), 32'h0);
        chk("t5_ready_before", 32'(mem_ready), 32'h0);
        load(32'h2000_0008, 1, 1'b1, -1);
        chk("t5_ovf_after", 32'(ld_ovf), 32'h1);
        chk("t5_mem_ready", 32'(mem_ready), 32'h1);
        apply_fetch("t5_word7", 32'h1C, 1'b0, 1'b0, 32'h2000_0007, 1'b1, 1'b0);
        apply_fetch("t5_word0", 32'h00, 1'b0, 1'b0, 32'h2000_0000, 1'b1, 1'b0);
        apply_fetch("t5_word3", 32'h0C, 1'b0, 1'b0, 32'h2000_0003, 1'b1, 1'b0);

        // Reload from RUN keeps the sticky overflow flag
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("t6_ovf_kept", 32'(ld_ovf), 32'h1);

        // T6: asynchronous reset in the middle of a load
        load(32'h3000_0000, 3, 1'b0, -1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_ld_ready", 32'(ld_ready), 32'h0);
        chk("t6_async_ld_ovf", 32'(ld_ovf), 32'h0);
        chk("t6_async_mem_ready", 32'(mem_ready), 32'h0);
        tick();
        rst = 1'b0;
        cyc = 0;
        while (!ld_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("t6_clear_cycles", 32'(cyc), 32'd8);
        load(32'h4000_0000, 2, 1'b1, -1);
        chk("t6_mem_ready", 32'(mem_ready), 32'h1);
        apply_fetch("t6_word0", 32'h00, 1'b0, 1'b0, 32'h4000_0000, 1'b1, 1'b0);
        apply_fetch("t6_word1", 32'h04, 1'b0, 1'b0, 32'h4000_0001, 1'b1, 1'b0);
        apply_fetch("t6_cleared", 32'h08, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("t6_ovf", 32'(ld_ovf), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
